// File: rtl/mul_div_unit.sv
// Iterative 32-bit unsigned multiply/divide unit feeding the register file write port.
// One shift-add / restoring-subtract datapath serves MUL, MULHU, DIVU and REMU.
// Every operation takes a fixed 32 iterations. The result is presented for one cycle on wr/wadd/wdata.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic             wr,
  output logic [4:0]       wadd,
  output logic [WIDTH-1:0] wdata
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic [4:0]         rd_q;
  // d_q: multiplicand for MUL*, divisor for DIV*.
  logic [WIDTH-1:0]   d_q;
  // hi_q: upper product / partial remainder. lo_q: multiplier bits / dividend-then-quotient.
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;
  logic [4:0]         wadd_q;
  logic [WIDTH-1:0]   wdata_q;

  logic [WIDTH:0]     sum, add, shl, diff;
  logic [WIDTH-1:0]   hi_nx, lo_nx;

  // One iteration of the shared datapath: shift-add for multiply, restoring step for divide.
  always_comb begin
    sum   = {1'b0, hi_q} + {1'b0, d_q};
    add   = lo_q[0] ? sum : {1'b0, hi_q};
    // Shifted remainder is kept on WIDTH+1 bits so the trial subtraction cannot lose a carry.
    shl   = {hi_q, lo_q[WIDTH-1]};
    diff  = shl - {1'b0, d_q};
    hi_nx = add[WIDTH:1];
    lo_nx = {add[0], lo_q[WIDTH-1:1]};
    if (op_q[1]) begin
      if (shl >= {1'b0, d_q}) begin
        hi_nx = diff[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = shl[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Control FSM with registered outputs; the result is captured on the final iteration edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      d_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wadd_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            op_q    <= op;
            rd_q    <= rd_in;
            d_q     <= op[1] ? b : a;
            lo_q    <= op[1] ? a : b;
            hi_q    <= '0;
          end
        end
        StRun: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            wadd_q  <= rd_q;
            // MULHU/REMU take the upper half, MUL/DIVU the lower half.
            wdata_q <= op_q[0] ? hi_nx : lo_nx;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign wr    = done_q;
  assign wadd  = wadd_q;
  assign wdata = wdata_q;

endmodule
